// File: rtl/otter_io_hub.sv
// OTTER MCU I/O hub: CPU clock-enable, reset sequencing, output registers,
// synchronised switches, debounced buttons and a sticky edge interrupt.
module otter_io_hub #(
  parameter logic [31:0] IN_BASE   = 32'h11008000,
  parameter logic [31:0] OUT_BASE  = 32'h1100C000,
  parameter int          N_OUT     = 4,
  parameter int          N_SW      = 16,
  parameter int          N_BTN     = 5,
  parameter int          CE_DIV    = 17,
  parameter int          DB_CYCLES = 4,
  parameter int          RST_HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic [N_SW-1:0]       switches,
  input  logic [N_BTN-1:0]      buttons,
  input  logic [31:0]           iobus_addr,
  input  logic [31:0]           iobus_out,
  input  logic                  iobus_wr,
  output logic [31:0]           iobus_in,
  output logic                  cpu_ce,
  output logic                  cpu_reset,
  output logic                  intr,
  output logic [N_OUT*32-1:0]   out_regs
);

  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic w_ce;
  logic w_we;

  // CPU clock enable: one pulse per 2^CE_DIV clk, or always on when CE_DIV=0.
  generate
    if (CE_DIV == 0) begin : g_ce_always
      assign w_ce = 1'b1;
    end else begin : g_ce_cnt
      logic [CE_DIV-1:0] r_ce_cnt;
      always_ff @(posedge clk) begin
        if (s_reset) r_ce_cnt <= '0;
        else         r_ce_cnt <= r_ce_cnt + CE_DIV'(1);
      end
      assign w_ce = &r_ce_cnt;
    end
  endgenerate

  assign cpu_ce = w_ce;

  typedef enum logic [1:0] {ST_INIT, ST_HOLD, ST_RUN} seq_t;

  seq_t              r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_cpu_reset;

  always_ff @(posedge clk) begin
    if (s_reset) begin
      r_state     <= ST_INIT;
      r_hold_cnt  <= '0;
      r_cpu_reset <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state     <= ST_HOLD;
          r_hold_cnt  <= '0;
          r_cpu_reset <= 1'b1;
        end
        ST_HOLD: begin
          if (w_ce) begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state     <= ST_RUN;
              r_cpu_reset <= 1'b0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
        end
        ST_RUN: r_cpu_reset <= 1'b0;
        default: begin
          r_state     <= ST_INIT;
          r_cpu_reset <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_reset = r_cpu_reset;

  // Writes land only on the cycle the CPU actually advances.
  assign w_we = iobus_wr & w_ce & ~r_cpu_reset;

  logic [31:0] r_out [N_OUT];

  always_ff @(posedge clk) begin
    if (s_reset) begin
      for (int i = 0; i < N_OUT; i++) r_out[i] <= '0;
    end else if (w_we) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (iobus_addr == OUT_BASE + 32'(4 * i)) r_out[i] <= iobus_out;
      end
    end
  end

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    assign out_regs[32*gi +: 32] = r_out[gi];
  end

  logic [N_SW-1:0]  r_sw_s1, r_sw_s2;
  logic [N_BTN-1:0] r_btn_s1, r_btn_s2;

  always_ff @(posedge clk) begin
    if (s_reset) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= switches;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= buttons;
      r_btn_s2 <= r_btn_s1;
    end
  end

  logic [DB_W-1:0]  r_db_cnt [N_BTN];
  logic [N_BTN-1:0] r_btn_db;
  logic [N_BTN-1:0] w_btn_db_nxt;
  logic [N_BTN-1:0] w_rise;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] r_pending;

  always_comb begin
    w_btn_db_nxt = r_btn_db;
    for (int b = 0; b < N_BTN; b++) begin
      if (r_btn_s2[b] != r_btn_db[b] && r_db_cnt[b] == DB_LAST)
        w_btn_db_nxt[b] = r_btn_s2[b];
    end
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      for (int b = 0; b < N_BTN; b++) r_db_cnt[b] <= '0;
      r_btn_db <= '0;
    end else begin
      for (int b = 0; b < N_BTN; b++) begin
        if (r_btn_s2[b] == r_btn_db[b] || r_db_cnt[b] == DB_LAST)
          r_db_cnt[b] <= '0;
        else
          r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
      end
      r_btn_db <= w_btn_db_nxt;
    end
  end

  // A new rising edge wins over a simultaneous write-1-to-clear.
  assign w_rise = w_btn_db_nxt & ~r_btn_db;
  assign w_clr  = (w_we && iobus_addr == IN_BASE + 32'd8) ? iobus_out[N_BTN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (s_reset) r_pending <= '0;
    else         r_pending <= (r_pending & ~w_clr) | w_rise;
  end

  assign intr = |r_pending;

  always_comb begin
    iobus_in = '0;
    if (iobus_addr == IN_BASE)              iobus_in = 32'(r_sw_s2);
    else if (iobus_addr == IN_BASE + 32'd4) iobus_in = 32'(r_btn_db);
    else if (iobus_addr == IN_BASE + 32'd8) iobus_in = 32'(r_pending);
    for (int i = 0; i < N_OUT; i++) begin
      if (iobus_addr == OUT_BASE + 32'(4 * i)) iobus_in = r_out[i];
    end
  end

endmodule
